mips_muldiv: RTL and testbench



---
 rtl/mips_pkg.sv | 23 ++
 rtl/muldiv_step.sv | 35 +++
 rtl/mips_muldiv.sv | 164 ++++++++++++++++
 tb/tb_mips_muldiv.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants, op codes and FSM encoding for the MIPS multiply/divide unit.
package mips_pkg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 5;

   localparam logic [1:0] OP_MULT  = 2'd0;
   localparam logic [1:0] OP_MULTU = 2'd1;
   localparam logic [1:0] OP_DIV   = 2'd2;
   localparam logic [1:0] OP_DIVU  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } muldiv_state_e;

   // Magnitude of x; a negative value is negated only when it is treated as signed.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic is_signed);
      return (is_signed && x[WIDTH-1]) ? WIDTH'(-x) : x;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: shift-add (multiply) or
// restoring shift-subtract (divide) on a double-width accumulator.
module muldiv_step
   import mips_pkg::*;
(
   input  logic               i_div,
   input  logic [2*WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0]   i_operand,
   output logic [2*WIDTH-1:0] o_acc
);

   logic [WIDTH:0]     add_sum;
   logic [WIDTH+1:0]   sub_diff;
   logic [2*WIDTH-1:0] shl;

   always_comb begin
      // Multiply: acc = {partial, multiplier}; add multiplicand when LSB set, then shift right.
      add_sum  = (WIDTH+1)'(i_acc[2*WIDTH-1:WIDTH])
               + (i_acc[0] ? (WIDTH+1)'(i_operand) : (WIDTH+1)'(0));
      // Divide: acc = {remainder, quotient}; the shifted-out MSB keeps the trial 33 bits wide.
      shl      = {i_acc[2*WIDTH-2:0], 1'b0};
      sub_diff = (WIDTH+2)'(i_acc[2*WIDTH-1:WIDTH-1]) - (WIDTH+2)'(i_operand);

      if (i_div) begin
         o_acc = shl;
         if (!sub_diff[WIDTH+1]) begin
            o_acc[2*WIDTH-1:WIDTH] = sub_diff[WIDTH-1:0];
            o_acc[0]               = 1'b1;
         end
      end else begin
         o_acc = {add_sum, i_acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Fixed 33-cycle latency: 32 magnitude iterations then one sign-fix cycle.
module mips_muldiv
   import mips_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_opa,
   input  logic [WIDTH-1:0] i_opb,
   input  logic             i_hi_we,
   input  logic             i_lo_we,
   input  logic [WIDTH-1:0] i_wdata,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   muldiv_state_e      state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opd_q, opd_d;
   logic               div_q, div_d;
   logic               sgn_q_q, sgn_q_d;
   logic               sgn_r_q, sgn_r_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [2*WIDTH-1:0] step_acc;

   // Operand decode for the start cycle.
   logic             st_signed;
   logic             st_div;
   logic             st_dbz;
   logic             st_sa;
   logic             st_sb;
   logic [WIDTH-1:0] st_amag;
   logic [WIDTH-1:0] st_bmag;

   assign st_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
   assign st_div    = (i_op == OP_DIV) || (i_op == OP_DIVU);
   assign st_dbz    = st_div && (i_opb == '0);
   assign st_sa     = st_signed && i_opa[WIDTH-1];
   assign st_sb     = st_signed && i_opb[WIDTH-1];
   // Divide by zero runs unsigned with no correction: quotient saturates to all ones,
   // remainder ends up equal to the raw dividend.
   assign st_amag   = st_dbz ? i_opa : mag(i_opa, st_signed);
   assign st_bmag   = mag(i_opb, st_signed);

   // Sign-fixed results, used only in FIX.
   logic [2*WIDTH-1:0] fix_prod;
   logic [WIDTH-1:0]   fix_quot;
   logic [WIDTH-1:0]   fix_rem;

   assign fix_prod = sgn_q_q ? (2*WIDTH)'(-acc_q) : acc_q;
   assign fix_quot = sgn_q_q ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
   assign fix_rem  = sgn_r_q ? WIDTH'(-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

   muldiv_step u_step (
      .i_div     (div_q),
      .i_acc     (acc_q),
      .i_operand (opd_q),
      .o_acc     (step_acc)
   );

   // State register and datapath registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opd_q   <= '0;
         div_q   <= 1'b0;
         sgn_q_q <= 1'b0;
         sgn_r_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opd_q   <= opd_d;
         div_q   <= div_d;
         sgn_q_q <= sgn_q_d;
         sgn_r_q <= sgn_r_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (i_start) state_d = ST_CALC;
         ST_CALC: if (cnt_q == CNT_W'(WIDTH-1)) state_d = ST_FIX;
         ST_FIX:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath and output register updates per state.
   always_comb begin
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opd_d   = opd_q;
      div_d   = div_q;
      sgn_q_d = sgn_q_q;
      sgn_r_d = sgn_r_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               div_d   = st_div;
               sgn_q_d = !st_dbz && (st_sa ^ st_sb);
               sgn_r_d = !st_dbz && st_sa;
               acc_d   = {{WIDTH{1'b0}}, (st_div ? st_amag : st_bmag)};
               opd_d   = st_div ? st_bmag : st_amag;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end else begin
               if (i_hi_we) hi_d = i_wdata;
               if (i_lo_we) lo_d = i_wdata;
            end
         end
         ST_CALC: begin
            acc_d = step_acc;
            cnt_d = cnt_q + CNT_W'(1);
         end
         ST_FIX: begin
            if (div_q) begin
               hi_d = fix_rem;
               lo_d = fix_quot;
            end else begin
               hi_d = fix_prod[2*WIDTH-1:WIDTH];
               lo_d = fix_prod[WIDTH-1:0];
            end
            busy_d = 1'b0;
            done_d = 1'b1;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   assign o_busy = busy_q;
   assign o_done = done_q;
   assign o_hi   = hi_q;
   assign o_lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: directed cases plus random ops against an arithmetic model.
module tb_mips_muldiv;
   import mips_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] opa, opb;
   logic             hi_we, lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy, done;
   logic [WIDTH-1:0] hi, lo;

   int n_checks = 0;
   int n_fail   = 0;

   logic [WIDTH-1:0] exp_hi = '0;
   logic [WIDTH-1:0] exp_lo = '0;

   always #5 clk = ~clk;

   mips_muldiv dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start),
      .i_op    (op),
      .i_opa   (opa),
      .i_opb   (opb),
      .i_hi_we (hi_we),
      .i_lo_we (lo_we),
      .i_wdata (wdata),
      .o_busy  (busy),
      .o_done  (done),
      .o_hi    (hi),
      .o_lo    (lo)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, want);
      end
   endtask

   // Architectural result from plain integer arithmetic.
   function automatic void model(input logic [1:0] m_op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r_hi, output logic [31:0] r_lo);
      logic [63:0] p;
      int          sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      case (m_op)
         OP_MULT:  begin p = 64'(longint'(sa) * longint'(sb)); r_hi = p[63:32]; r_lo = p[31:0]; end
         OP_MULTU: begin p = {32'b0, a} * {32'b0, b};          r_hi = p[63:32]; r_lo = p[31:0]; end
         default: begin
            if (b == 0) begin
               r_lo = 32'hFFFF_FFFF; r_hi = a;
            end else if (m_op == OP_DIVU) begin
               r_lo = a / b; r_hi = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               r_lo = 32'h8000_0000; r_hi = 32'h0;
            end else begin
               r_lo = 32'(sa / sb); r_hi = 32'(sa % sb);
            end
         end
      endcase
   endfunction

   // Issue one op, optionally poke a stray start / MTHI mid-flight, and check the result.
   task automatic run_op(input string tag, input logic [1:0] m_op, input logic [31:0] a,
                         input logic [31:0] b, input int stray_start_cyc, input int hi_we_cyc);
      int first_done;
      int n_done;
      logic busy_at_done;
      model(m_op, a, b, exp_hi, exp_lo);
      first_done   = -1;
      n_done       = 0;
      busy_at_done = 1'b1;
      start = 1'b1; op = m_op; opa = a; opb = b;
      @(posedge clk); #1;
      start = 1'b0;
      opa = $urandom; opb = $urandom;
      check({tag, ".busy_on_start"}, 32'(busy), 32'd1);
      for (int n = 1; n <= 36; n++) begin
         if (n == stray_start_cyc) begin start = 1'b1; op = OP_MULTU; opa = 32'h55; opb = 32'h55; end
         if (n == hi_we_cyc) begin hi_we = 1'b1; wdata = 32'h1234; end
         @(posedge clk); #1;
         start = 1'b0; hi_we = 1'b0;
         if (n == 20) begin
            check({tag, ".busy_mid"}, 32'(busy), 32'd1);
         end
         if (done) begin
            n_done++;
            if (first_done < 0) begin first_done = n; busy_at_done = busy; end
         end
      end
      check({tag, ".latency"}, 32'(first_done), 32'd33);
      check({tag, ".done_pulses"}, 32'(n_done), 32'd1);
      check({tag, ".busy_at_done"}, 32'(busy_at_done), 32'd0);
      check({tag, ".hi"}, hi, exp_hi);
      check({tag, ".lo"}, lo, exp_lo);
   endtask

   initial begin
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b;
      int          n_done;

      rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset.busy", 32'(busy), 32'd0);
      check("reset.done", 32'(done), 32'd0);
      check("reset.hi", hi, 32'd0);
      check("reset.lo", lo, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op("mult_neg3x7",   OP_MULT,  32'hFFFF_FFFD, 32'd7,        -1, -1);
      run_op("multu_max",     OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
      run_op("divu_100_7",    OP_DIVU,  32'd100,       32'd7,        -1, -1);
      run_op("div_neg7_2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,        -1, -1);
      run_op("div_overflow",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
      run_op("divu_by_zero",  OP_DIVU,  32'd5,         32'd0,        -1, -1);
      run_op("div_by_zero_n", OP_DIV,   32'hFFFF_FFF0, 32'd0,        -1, -1);
      run_op("multu_stray",   OP_MULTU, 32'd3,         32'd4,        10,  5);

      // MTLO while idle
      lo_we = 1'b1; wdata = 32'hABCD;
      @(posedge clk); #1;
      lo_we = 1'b0;
      check("mtlo.lo", lo, 32'h0000_ABCD);
      check("mtlo.hi_kept", hi, exp_hi);

      // Start and MTHI in the same idle cycle: start wins, write dropped
      hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      run_op("start_vs_mthi", OP_MULTU, 32'd6, 32'd7, -1, -1);
      hi_we = 1'b0;

      // Reset in mid-flight
      start = 1'b1; op = OP_DIVU; opa = 32'd9; opb = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_mid.busy", 32'(busy), 32'd0);
      check("rst_mid.hi", hi, 32'd0);
      check("rst_mid.lo", lo, 32'd0);
      n_done = 0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      check("rst_mid.no_done", 32'(n_done), 32'd0);
      run_op("after_rst_mult", OP_MULT, 32'd2, 32'd3, -1, -1);

      // Random ops, with occasional MTHI/MTLO in between
      for (int i = 0; i < 40; i++) begin
         r_op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: r_a = 32'h8000_0000;
            1: r_a = $urandom_range(0, 300);
            default: r_a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: r_b = 32'd0;
            1: r_b = 32'hFFFF_FFFF;
            2: r_b = $urandom_range(1, 50);
            default: r_b = $urandom;
         endcase
         run_op("rand", r_op, r_a, r_b, -1, -1);
         if (i % 8 == 3) begin
            hi_we = 1'b1; wdata = $urandom;
            exp_hi = wdata;
            @(posedge clk); #1;
            hi_we = 1'b0;
            check("rand.mthi", hi, exp_hi);
            check("rand.mthi_lo_kept", lo, exp_lo);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
